// File: rtl/alu_pkg.sv
// Shared op-codes and sequencer state type for the bit-serial ALU.
// Imported by the 1-bit cell and by the controller.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU cell: AND/OR/XOR or full-adder slice.
// Cout is only meaningful for ADD and is 0 otherwise.
module alu_1bit
  import alu_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic Op0,
  input  logic Op1,
  output logic Result,
  output logic Cout
);

  // Combinational bit operation selected by {Op1, Op0}
  always_comb begin
    Result = 1'b0;
    Cout   = 1'b0;
    unique case ({Op1, Op0})
      OP_AND: Result = A & B;
      OP_OR:  Result = A | B;
      OP_XOR: Result = A ^ B;
      OP_ADD: begin
        Result = A ^ B ^ Cin;
        Cout   = (A & B) | (Cin & (A ^ B));
      end
      default: Result = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU controller: one operand bit per clock, LSB first.
// Optional subtract mode: define BIT_SERIAL_ALU_SUB_EN.
module bit_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
`ifdef BIT_SERIAL_ALU_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;

  logic             w_is_add;
  logic             w_b_bit;
  logic             w_cin0;
  logic             w_bit;
  logic             w_cell_cout;
  logic             w_carry_nx;
  logic [WIDTH-1:0] w_sh_nx;

  assign w_is_add = (r_op == OP_ADD);

`ifdef BIT_SERIAL_ALU_SUB_EN
  logic r_sub;

  // Subtract is a + ~b + 1: invert B and seed the carry with 1
  assign w_b_bit = r_b[0] ^ (r_sub & w_is_add);
  assign w_cin0  = sub & (op == OP_ADD);

  // Subtract flag travels with the op-code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (start && r_state != S_RUN) begin
      r_sub <= sub;
    end
  end
`else
  assign w_b_bit = r_b[0];
  assign w_cin0  = 1'b0;
`endif

  alu_1bit u_cell (
    .A      (r_a[0]),
    .B      (w_b_bit),
    .Cin    (r_carry),
    .Op0    (r_op[0]),
    .Op1    (r_op[1]),
    .Result (w_bit),
    .Cout   (w_cell_cout)
  );

  // Logic ops never propagate a carry
  assign w_carry_nx = w_is_add & w_cell_cout;
  assign w_sh_nx    = {w_bit, r_sh[WIDTH-1:1]};

  // Sequencer: accept in IDLE/DONE, shift WIDTH bits, publish in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_result <= '0;
      r_op     <= OP_AND;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_carry <= w_cin0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sh    <= w_sh_nx;
          r_carry <= w_carry_nx;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          if (r_cnt == LAST) begin
            r_state  <= S_DONE;
            r_result <= w_sh_nx;
            r_cout   <= w_carry_nx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu (WIDTH=8).
// Define BIT_SERIAL_ALU_SUB_EN to also exercise subtract mode.
module tb_bit_serial_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int checks = 0;
  int errors = 0;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
`ifdef BIT_SERIAL_ALU_SUB_EN
    .sub    (sub),
`endif
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, {cout, result}
  function automatic logic [W:0] model(input logic [1:0] o,
                                       input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic s);
    logic [W:0] r;
    case (o)
      2'b00:   r = {1'b0, x & y};
      2'b01:   r = {1'b0, x | y};
      2'b10:   r = {1'b0, x ^ y};
      default: begin
        if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   r = {1'b0, x} + {1'b0, y};
      end
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic s,
                       input logic [W-1:0] er, input logic ec,
                       input string nm);
    int at;
    int bc;
    at = -1;
    bc = 0;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    sub = s;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 1) check({nm, " busy_next"}, busy, 1);
      if (busy) bc++;
      if (done) begin
        at = k;
        break;
      end
    end
    check({nm, " latency"}, at, W + 1);
    check({nm, " busy_cycles"}, bc, W);
    check({nm, " result"}, result, er);
    check({nm, " cout"}, cout, ec);
  endtask

  vec_t vecs[5];
  logic [W:0] e;
  int dc;
  int at2;

  initial begin
    vecs[0] = '{2'b11, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[1] = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[2] = '{2'b10, 8'hAA, 8'hFF, 8'h55, 1'b0};
    vecs[3] = '{2'b11, 8'h12, 8'h34, 8'h46, 1'b0};
    vecs[4] = '{2'b01, 8'h0F, 8'h30, 8'h3F, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    sub = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset cout", cout, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle no done", done, 0);

    // Directed vectors, idle gap after each, output hold checked
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
            vecs[i].res, vecs[i].co, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d pulse", i), done, 0);
      check($sformatf("vec%0d hold", i), result, vecs[i].res);
    end

    // Start held through RUN with new operands: ignored until DONE
    start = 1'b1;
    op = 2'b11;
    a = 8'h10;
    b = 8'h20;
    @(negedge clk);
    op = 2'b10;
    a = 8'hFF;
    b = 8'h0F;
    at2 = -1;
    for (int k = 2; k <= W + 4; k++) begin
      @(negedge clk);
      if (done) begin
        at2 = k;
        break;
      end
    end
    check("held first latency", at2, W + 1);
    check("held first result", result, 8'h30);
    check("held first cout", cout, 0);
    at2 = -1;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 1) check("held busy_next", busy, 1);
      if (done) begin
        at2 = k;
        break;
      end
    end
    check("held second gap", at2, W + 1);
    check("held second result", result, 8'hF0);
    @(negedge clk);

    // Reset in the middle of RUN aborts with no done pulse
    start = 1'b1;
    op = 2'b11;
    a = 8'h55;
    b = 8'h66;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    check("abort quiet", dc, 0);
    do_op(2'b11, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_abort");

    // Back-to-back: new start issued in the DONE cycle
    do_op(2'b01, 8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0, "b2b");
    @(negedge clk);

`ifdef BIT_SERIAL_ALU_SUB_EN
    do_op(2'b11, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, "sub5_7");
    do_op(2'b11, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, "sub7_5");
    do_op(2'b00, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, "sub_logic");
    @(negedge clk);
`endif

    // Randomised against the arithmetic model, mixed gaps
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      logic         rs;
      ro = 2'($urandom_range(0, 3));
      rx = W'($urandom);
      ry = W'($urandom);
`ifdef BIT_SERIAL_ALU_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      e = model(ro, rx, ry, rs);
      do_op(ro, rx, ry, rs, e[W-1:0], e[W], $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu.md
Name: bit_serial_alu

Overview:
- Multi-cycle, bit-serial ALU controller: the initiator that drives a 1-bit ALU cell one bit per clock, LSB first.
- Captures WIDTH-bit operands on a start handshake, iterates WIDTH cycles with a registered carry, and assembles the result in a shift register.
- Sits between the datapath register file and the 1-bit ALU cell; trades latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled in IDLE or DONE state.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 ADD.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and cout are valid.
- result  output  WIDTH  final result; held until the next accepted start completes.
- cout  output  1  final carry for ADD; 0 for logic ops.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, result=0, cout=0.
  - Operand registers, bit counter and carry register are cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 means accept: latch a, b and op; carry register=0; bit counter=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Present a_sh[0], b_sh[0], carry and op to the cell.
  - Shift the cell result into result_sh from the MSB side; carry register <= cell Cout.
  - Shift a_sh and b_sh right by 1; counter++.
  - When counter==WIDTH-1, go to DONE that cycle.
  - start is ignored while in RUN (no queuing).
- DONE (exactly one cycle):
  - done=1; result=result_sh; cout=carry register.
  - start=1 in DONE is accepted exactly as in IDLE and goes straight to RUN.
  - Otherwise go to IDLE.
- Latency:
  - start accepted at edge N; bits processed on edges N+1..N+WIDTH; done high in the cycle after edge N+WIDTH.
  - Start-to-done is WIDTH+1 cycles. Back-to-back throughput is one op per WIDTH+1 cycles.
- Outputs:
  - result and cout are registered and update only on entry to DONE.
  - result and cout hold their values through IDLE and the following RUN.
- Carry rules:
  - For op!=11 the carry register is forced to 0 every RUN cycle.
  - Therefore cout=0 for logic ops.
- Arithmetic: ADD is modulo 2^WIDTH; overflow is visible only through cout.
- Counter width is $clog2(WIDTH). The counter never wraps, because the DONE transition occurs at WIDTH-1.
- rst asserted mid-RUN aborts the operation: all state clears immediately and no done pulse is produced.

Optional Feature:
- Macro: BIT_SERIAL_ALU_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), latched with op.
  - When op=11 and sub=1: the B bit fed to the cell is inverted, and the carry register initialises to 1 on accept. This computes a-b.
  - cout=1 means no borrow. sub is ignored for logic ops.
- When undefined: no sub port; op=11 is always ADD.

Decomposition:
- Shared package alu_pkg:
  - Op-code localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11.
  - State enum typedef (IDLE/RUN/DONE).
- Sub-module: one instance of the team's existing alu_1bit cell, with ports A, B, Cin, Op0, Op1, Result, Cout.
- The sequencer, shift registers and carry flop live in bit_serial_alu itself.

Test Plan:
- WIDTH=8, op=11, a=0xFF, b=0x01 -> done 9 cycles after accept; result=0x00, cout=1; busy high for exactly 8 cycles.
- op=00, a=0xF0, b=0x3C -> result=0x30, cout=0. Then op=10, a=0xAA, b=0xFF -> result=0x55, cout=0.
- Start held high during RUN with different a/b/op -> ignored. The original op completes; a new op is accepted only at DONE; the second done comes WIDTH+1 cycles after the first.
- rst pulsed at cycle 4 of RUN -> busy, done, result and cout all 0 immediately; no done pulse; next start works normally (0x12+0x34 -> 0x46).
- Back-to-back: start asserted in DONE cycle, op=01, a=0x0F, b=0x30 -> busy the next cycle; result=0x3F after WIDTH+1 cycles.
- With BIT_SERIAL_ALU_SUB_EN, op=11, sub=1: a=0x05, b=0x07 -> result=0xFE, cout=0. Then a=0x07, b=0x05 -> result=0x02, cout=1.
